// File: rtl/dsd_maximizer_pkg.sv
// rtl/dsd_maximizer_pkg.sv - shared types and helpers for the DSD level mapper
//
// Purpose: soft-mute FSM state encoding and the unity-gain helper used by the
//          gain ramp and the level mapper top.
// Contents:
//    ramp_state_t  ST_MUTED, ST_RAMP_UP, ST_PLAY, ST_RAMP_DOWN
//    gain_unity()  2**gain_width, the gain value that passes LEVEL unchanged

package dsd_maximizer_pkg;

   typedef enum logic [1:0] {
      ST_MUTED     = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_PLAY      = 2'd2,
      ST_RAMP_DOWN = 2'd3
   } ramp_state_t;

   function automatic int unsigned gain_unity(input int unsigned gain_width);
      return 32'd1 << gain_width;
   endfunction

endpackage

// File: rtl/dsd_gain_ramp.sv
// rtl/dsd_gain_ramp.sv - soft-mute FSM with saturating linear gain counter
//
// Purpose: produces the gain G (0..2**GAIN_WIDTH) applied to the full-scale
//          level. The FSM and gain move only on cycles where advance=1.
// Ports:
//    clk      in   1             clock, posedge
//    reset    in   1             synchronous, active-high
//    advance  in   1             a new sample is being accepted this cycle
//    mute     in   1             1 = ramp toward silence, 0 = ramp toward unity
//    gain     out  GAIN_WIDTH+1  gain held before the current sample's update
//    busy     out  1             registered: state is RAMP_UP or RAMP_DOWN
//    muted    out  1             registered: state is MUTED

module dsd_gain_ramp
   import dsd_maximizer_pkg::*;
#(
   parameter int GAIN_WIDTH = 16,
   parameter int RAMP_STEP  = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  advance,
   input  logic                  mute,
   output logic [GAIN_WIDTH:0]   gain,
   output logic                  busy,
   output logic                  muted
);

   localparam logic [GAIN_WIDTH+1:0] UNITY_W = (GAIN_WIDTH+2)'(gain_unity(GAIN_WIDTH));
   localparam logic [GAIN_WIDTH:0]   STEP_G  = (GAIN_WIDTH+1)'(RAMP_STEP);

   ramp_state_t state;

   // One extra bit on the up-sum so the saturation compare cannot wrap.
   logic [GAIN_WIDTH+1:0] gain_up;
   logic [GAIN_WIDTH:0]   gain_dn;
   logic                  reaches_zero;

   assign gain_up      = {1'b0, gain} + {1'b0, STEP_G};
   assign gain_dn      = gain - STEP_G;
   assign reaches_zero = (gain <= STEP_G);

   // Outside MUTED the direction of each sample's step follows mute directly,
   // so a reversal (PLAY->RAMP_DOWN, RAMP_UP<->RAMP_DOWN) already takes its
   // first step on the sample that reverses. Leaving MUTED does not step.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_MUTED;
         gain  <= '0;
         busy  <= 1'b0;
         muted <= 1'b1;
      end else if (advance) begin
         if (state == ST_MUTED) begin
            if (!mute) begin
               state <= ST_RAMP_UP;
               busy  <= 1'b1;
               muted <= 1'b0;
            end
         end else if (mute) begin
            if (reaches_zero) begin
               gain  <= '0;
               state <= ST_MUTED;
               busy  <= 1'b0;
               muted <= 1'b1;
            end else begin
               gain  <= gain_dn;
               state <= ST_RAMP_DOWN;
               busy  <= 1'b1;
               muted <= 1'b0;
            end
         end else begin
            if (gain_up >= UNITY_W) begin
               gain  <= UNITY_W[GAIN_WIDTH:0];
               state <= ST_PLAY;
               busy  <= 1'b0;
               muted <= 1'b0;
            end else begin
               gain  <= gain_up[GAIN_WIDTH:0];
               state <= ST_RAMP_UP;
               busy  <= 1'b1;
               muted <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/dsd_level_mapper.sv
// rtl/dsd_level_mapper.sv - multi-channel DSD bit to signed PCM level mapper
//
// Purpose: maps each channel's quantizer bit to +MAG (bit 1) or -MAG (bit 0),
//          MAG = (level * G) >> GAIN_WIDTH, with a shared soft-mute gain ramp.
//          Two-stage pipeline: dsd_valid to pcm_valid is exactly 2 cycles.
// Ports:
//    bclk       in   1                          bit clock, posedge
//    reset      in   1                          synchronous, active-high
//    dsd_valid  in   1                          strobe: dsd_data holds a new sample
//    dsd_data   in   CHANNELS                   quantizer bit per channel
//    level      in   PCM_BIT_LENGTH-1           unsigned full-scale, sampled with dsd_valid
//    mute       in   1                          1 = ramp to silence, 0 = ramp to unity
//    pcm_valid  out  1                          strobe: pcm_data updated
//    pcm_data   out  CHANNELS*PCM_BIT_LENGTH    signed words, channel c at [c*W +: W]
//    ramp_busy  out  1                          gain ramp in progress
//    muted      out  1                          ramp FSM in MUTED

module dsd_level_mapper #(
   parameter int PCM_BIT_LENGTH = 32,
   parameter int CHANNELS       = 2,
   parameter int GAIN_WIDTH     = 16,
   parameter int RAMP_STEP      = 256
) (
   input  logic                               bclk,
   input  logic                               reset,
   input  logic                               dsd_valid,
   input  logic [CHANNELS-1:0]                dsd_data,
   input  logic [PCM_BIT_LENGTH-2:0]          level,
   input  logic                               mute,
   output logic                               pcm_valid,
   output logic [CHANNELS*PCM_BIT_LENGTH-1:0] pcm_data,
   output logic                               ramp_busy,
   output logic                               muted
);

   localparam int W  = PCM_BIT_LENGTH;
   localparam int PW = W - 1 + GAIN_WIDTH;

   logic [GAIN_WIDTH:0] gain;

   dsd_gain_ramp #(
      .GAIN_WIDTH (GAIN_WIDTH),
      .RAMP_STEP  (RAMP_STEP)
   ) u_gain_ramp (
      .clk     (bclk),
      .reset   (reset),
      .advance (dsd_valid),
      .mute    (mute),
      .gain    (gain),
      .busy    (ramp_busy),
      .muted   (muted)
   );

   // G <= 2**GAIN_WIDTH, so level*G fits in W-1+GAIN_WIDTH bits and the
   // shifted magnitude never exceeds level (W-1 bits).
   logic [PW-1:0] product;
   logic [W-2:0]  mag;

   assign product = {{GAIN_WIDTH{1'b0}}, level} * {{(W-2){1'b0}}, gain};
   assign mag     = (W-1)'(product >> GAIN_WIDTH);

   logic                s1_valid;
   logic [CHANNELS-1:0] s1_bits;
   logic [W-2:0]        s1_mag;

   always_ff @(posedge bclk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_bits  <= '0;
         s1_mag   <= '0;
      end else begin
         s1_valid <= dsd_valid;
         if (dsd_valid) begin
            s1_bits <= dsd_data;
            s1_mag  <= mag;
         end
      end
   end

   // MAG has a clear sign bit, so -MAG is never 0x80..0 and the output
   // stays symmetric around zero.
   logic [W-1:0]            mag_pos;
   logic [W-1:0]            mag_neg;
   logic [CHANNELS*W-1:0]   pcm_next;

   assign mag_pos = {1'b0, s1_mag};
   assign mag_neg = -mag_pos;

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
      assign pcm_next[ch*W +: W] = s1_bits[ch] ? mag_pos : mag_neg;
   end

   always_ff @(posedge bclk) begin
      if (reset) begin
         pcm_valid <= 1'b0;
         pcm_data  <= '0;
      end else begin
         pcm_valid <= s1_valid;
         if (s1_valid) begin
            pcm_data <= pcm_next;
         end
      end
   end

endmodule
